// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial datapath: word/coefficient types,
// the inverse-solver state encoding and a helper that slices one coefficient.
package poly_pkg;

   localparam int WIDTH  = 32;
   localparam int DEGREE = 4;
   localparam int CNT_W  = $clog2(DEGREE + 1);

   typedef logic signed [WIDTH-1:0] word_t;
   typedef word_t coef_arr_t [DEGREE+1];

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK,
      S_EVAL_LO,
      S_EVAL_HI,
      S_EVAL_MID,
      S_DONE
   } solver_state_e;

   // a[idx] lives at bits idx*WIDTH +: WIDTH of the flat coefficient bus
   function automatic word_t coefWord(input logic [(DEGREE+1)*WIDTH-1:0] flat, input int idx);
      return word_t'(flat[idx*WIDTH +: WIDTH]);
   endfunction

endpackage

// File: rtl/horner_seq_eval.sv
// Sequential Horner engine: a start pulse loads a[N], then N multiply-add steps;
// done pulses for one cycle with the wrapped WIDTH-bit p(x) on value.
module horner_seq_eval
   import poly_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      start,
   input  word_t     x,
   input  coef_arr_t coef,
   output logic      done,
   output word_t     value
);

   word_t            r_acc;
   word_t            r_x;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;

   // r_cnt holds the index of the next coefficient to fold in, plus one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= '0;
         r_x    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_acc  <= coef[DEGREE];
            r_x    <= x;
            r_cnt  <= CNT_W'(DEGREE);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_acc <= r_acc * r_x + coef[r_cnt - 1'b1];
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign done  = r_done;
   assign value = r_acc;

endmodule

// File: rtl/poly_inverse_solver.sv
// Bisection solver for p(x)=target over a signed bracket, sharing one sequential
// Horner evaluator for lo, hi and every midpoint.
module poly_inverse_solver
   import poly_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [(DEGREE+1)*WIDTH-1:0]   coef,
   input  logic [WIDTH-1:0]              target,
   input  logic [WIDTH-1:0]              lo,
   input  logic [WIDTH-1:0]              hi,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              x_out,
   output logic                          exact,
   output logic                          err,
   output logic                          busy
);

   solver_state_e r_state, w_nextState;
   coef_arr_t     r_coef;
   word_t         r_target, r_lo, r_hi, r_xOut;
   logic          r_sLo, r_exact, r_err, r_startPending;

   logic              w_start, w_evalDone, w_loGtHi, w_dZero, w_dSign, w_sameSign;
   word_t             w_evalValue, w_evalX, w_midWord;
   logic signed [WIDTH:0] w_d, w_span, w_half, w_spanAfter;

   horner_seq_eval u_eval (
      .clk   (clk),
      .rst   (rst),
      .start (w_start),
      .x     (w_evalX),
      .coef  (r_coef),
      .done  (w_evalDone),
      .value (w_evalValue)
   );

   // Differences are taken one bit wider so the sign never wraps
   assign w_d         = {w_evalValue[WIDTH-1], w_evalValue} - {r_target[WIDTH-1], r_target};
   assign w_dZero     = (w_d == '0);
   assign w_dSign     = w_d[WIDTH];
   assign w_sameSign  = (w_dSign == r_sLo);
   assign w_loGtHi    = (r_lo > r_hi);
   assign w_span      = {r_hi[WIDTH-1], r_hi} - {r_lo[WIDTH-1], r_lo};
   assign w_half      = w_span >>> 1;
   assign w_midWord   = r_lo + word_t'(w_half[WIDTH-1:0]);
   assign w_spanAfter = w_sameSign ? (w_span - w_half) : w_half;
   assign w_evalX     = (r_state == S_CHK)     ? r_lo :
                        (r_state == S_EVAL_HI) ? r_hi : w_midWord;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:     if (in_valid) w_nextState = S_CHK;
         S_CHK:      w_nextState = w_loGtHi ? S_DONE : S_EVAL_LO;
         S_EVAL_LO:  if (w_evalDone)
                        w_nextState = (w_dZero || r_lo == r_hi) ? S_DONE : S_EVAL_HI;
         S_EVAL_HI:  if (w_evalDone)
                        w_nextState = (w_dZero || w_sameSign || w_span == (WIDTH+1)'(1))
                                      ? S_DONE : S_EVAL_MID;
         S_EVAL_MID: if (w_evalDone)
                        w_nextState = (w_dZero || w_spanAfter == (WIDTH+1)'(1))
                                      ? S_DONE : S_EVAL_MID;
         S_DONE:     if (out_ready) w_nextState = S_IDLE;
         default:    w_nextState = S_IDLE;
      endcase
   end

   // The lo evaluation is launched from CHK itself, so CHK doubles as its load cycle
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      w_start   = r_startPending;
      case (r_state)
         S_IDLE:  in_ready  = 1'b1;
         S_CHK:   begin busy = 1'b1; w_start = !w_loGtHi; end
         S_DONE:  out_valid = 1'b1;
         default: busy      = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= DEGREE; i++) r_coef[i] <= '0;
         r_target       <= '0;
         r_lo           <= '0;
         r_hi           <= '0;
         r_xOut         <= '0;
         r_sLo          <= 1'b0;
         r_exact        <= 1'b0;
         r_err          <= 1'b0;
         r_startPending <= 1'b0;
      end else begin
         r_startPending <= w_evalDone &&
                           (w_nextState == S_EVAL_HI || w_nextState == S_EVAL_MID);
         case (r_state)
            S_IDLE: if (in_valid) begin
               for (int i = 0; i <= DEGREE; i++) r_coef[i] <= coefWord(coef, i);
               r_target <= target;
               r_lo     <= lo;
               r_hi     <= hi;
            end
            S_CHK: if (w_loGtHi) begin
               r_xOut <= r_lo; r_exact <= 1'b0; r_err <= 1'b1;
            end
            S_EVAL_LO: if (w_evalDone) begin
               r_sLo   <= w_dSign;
               r_xOut  <= r_lo;
               r_exact <= w_dZero;
               r_err   <= !w_dZero;
            end
            S_EVAL_HI: if (w_evalDone) begin
               r_xOut  <= w_dZero ? r_hi : r_lo;
               r_exact <= w_dZero;
               r_err   <= !w_dZero && w_sameSign;
            end
            S_EVAL_MID: if (w_evalDone) begin
               if (w_sameSign) r_lo <= w_midWord;
               else            r_hi <= w_midWord;
               r_xOut  <= (w_dZero || w_sameSign) ? w_midWord : r_lo;
               r_exact <= w_dZero;
               r_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign x_out = r_xOut;
   assign exact = r_exact;
   assign err   = r_err;

endmodule

// File: tb/tb_poly_inverse_solver.sv
// Directed bench for poly_inverse_solver: hand-computed roots, bracket errors,
// latency, mid-search reset and result back-pressure.
module tb_poly_inverse_solver;
   import poly_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        in_valid;
   logic                        in_ready;
   logic [(DEGREE+1)*WIDTH-1:0] coef;
   logic [WIDTH-1:0]            target;
   logic [WIDTH-1:0]            lo;
   logic [WIDTH-1:0]            hi;
   logic                        out_valid;
   logic                        out_ready;
   logic [WIDTH-1:0]            x_out;
   logic                        exact;
   logic                        err;
   logic                        busy;

   int checks   = 0;
   int failures = 0;

   poly_inverse_solver dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .coef      (coef),
      .target    (target),
      .lo        (lo),
      .hi        (hi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_out     (x_out),
      .exact     (exact),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [WIDTH-1:0] observed,
                        input logic signed [WIDTH-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Presents one request at a negedge and returns at the negedge after the accept edge
   task automatic applyStimulus(input int a4, input int a3, input int a2, input int a1,
                                input int a0, input int y, input int l, input int h);
      int guard;
      @(negedge clk);
      coef     = {a4, a3, a2, a1, a0};
      target   = y;
      lo       = l;
      hi       = h;
      in_valid = 1'b1;
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("accept_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits for the result, counting cycles from the accept edge, then consumes it
   task automatic checkOutput(input string tag, input int expX, input logic expExact,
                              input logic expErr, input int expLat);
      int lat;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_valid"}, out_valid, 1);
      if (expLat >= 0) check({tag, "_latency"}, lat, expLat);
      check({tag, "_x"}, x_out, expX);
      check({tag, "_exact"}, exact, expExact);
      check({tag, "_err"}, err, expErr);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_released"}, out_valid, 0);
      check({tag, "_idle"}, in_ready, 1);
   endtask

   initial begin
      int lat;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      coef      = '0;
      target    = '0;
      lo        = '0;
      hi        = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_x_out", x_out, 0);
      check("rst_exact", exact, 0);
      check("rst_err", err, 0);
      rst = 1'b0;

      // p = x^3
      applyStimulus(0, 1, 0, 0, 0, 27, 0, 10);
      check("cube27_busy", busy, 1);
      check("cube27_not_ready", in_ready, 0);
      checkOutput("cube27", 3, 1'b1, 1'b0, -1);

      applyStimulus(0, 1, 0, 0, 0, 30, 0, 10);
      checkOutput("cube30", 3, 1'b0, 1'b0, -1);

      applyStimulus(0, 1, 0, 0, 0, -8, -10, 10);
      checkOutput("cube_neg8", -2, 1'b1, 1'b0, -1);

      // a = {2,-3,1,5,-4}: p(1)=1, p(2)=-24, p(0)=2
      applyStimulus(-4, 5, 1, -3, 2, 0, 1, 2);
      checkOutput("quart_12", 1, 1'b0, 1'b0, 12);

      applyStimulus(-4, 5, 1, -3, 2, 0, 0, 1);
      checkOutput("quart_nosign", 0, 1'b0, 1'b1, 12);

      applyStimulus(-4, 5, 1, -3, 2, 0, 5, 3);
      checkOutput("quart_lo_gt_hi", 5, 1'b0, 1'b1, 1);

      // Degenerate bracket: root found at lo, and no root
      applyStimulus(0, 1, 0, 0, 0, 27, 3, 3);
      checkOutput("point_exact", 3, 1'b1, 1'b0, 6);

      applyStimulus(0, 1, 0, 0, 0, 27, 4, 4);
      checkOutput("point_err", 4, 1'b0, 1'b1, 6);

      // Abort during the first midpoint evaluation
      applyStimulus(0, 1, 0, 0, 0, 27, 0, 10);
      repeat (14) @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_no_result", out_valid, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_x_out", x_out, 0);
      applyStimulus(0, 1, 0, 0, 0, 30, 0, 10);
      checkOutput("after_abort", 3, 1'b0, 1'b0, -1);

      // Back-pressure: result must hold while new requests are offered
      applyStimulus(0, 1, 0, 0, 0, -8, -10, 10);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check("hold_arrived", out_valid, 1);
      coef     = {32'sd0, 32'sd0, 32'sd0, 32'sd1, 32'sd0};
      target   = 7;
      lo       = 0;
      hi       = 20;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_x", x_out, -2);
         check("hold_exact", exact, 1);
         check("hold_err", err, 0);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hold_released", out_valid, 0);
      check("hold_idle", in_ready, 1);
      @(negedge clk);
      check("hold_ignored_busy", busy, 0);
      check("hold_ignored_valid", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
